// File: rtl/rpn_calc_ctrl.sv
// rpn_calc_ctrl: entry sequencer for the RPN calculator.
// Steps through operand A, operand B and opcode entry from debounced Enter/Undo
// buttons. Holds the ALU operand/opcode registers, captures the ALU result and
// flags, and picks the value shown on the 7-segment driver.
//
// state        | code | meaning
// WAIT_OPA     | 0    | idle, waiting for Enter to take operand A
// LOAD_OPA     | 1    | OpA <= DataIn this edge
// WAIT_OPB     | 2    | waiting for operand B (Undo returns to WAIT_OPA)
// LOAD_OPB     | 3    | OpB <= DataIn this edge
// WAIT_OP      | 4    | waiting for opcode (Undo returns to WAIT_OPB)
// LOAD_OP      | 5    | OpCode <= DataIn[OP_W-1:0] this edge
// SHOW_RESULT  | 6    | result displayed; Enter chains, Undo backs out
// (unused)     | 7    | recovers to WAIT_OPA

module rpn_calc_ctrl #(
  parameter int WIDTH  = 16,
  parameter int OP_W   = 2,
  parameter int FLAG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Enter,
  input  logic              Undo,
  input  logic [WIDTH-1:0]  DataIn,
  input  logic [WIDTH-1:0]  AluResult,
  input  logic [FLAG_W-1:0] AluFlags,
  output logic [WIDTH-1:0]  OpA,
  output logic [WIDTH-1:0]  OpB,
  output logic [OP_W-1:0]   OpCode,
  output logic [WIDTH-1:0]  Result,
  output logic [FLAG_W-1:0] Flags,
  output logic [2:0]        Status,
  output logic              ResultValid,
  output logic [WIDTH-1:0]  DisplayValue
);

  localparam logic [2:0] S_WAIT_OPA    = 3'd0;
  localparam logic [2:0] S_LOAD_OPA    = 3'd1;
  localparam logic [2:0] S_WAIT_OPB    = 3'd2;
  localparam logic [2:0] S_LOAD_OPB    = 3'd3;
  localparam logic [2:0] S_WAIT_OP     = 3'd4;
  localparam logic [2:0] S_LOAD_OP     = 3'd5;
  localparam logic [2:0] S_SHOW_RESULT = 3'd6;

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic              enter_prev;
  logic              undo_prev;
  logic              enter_edge;
  logic              undo_edge;
  // High during the first SHOW_RESULT cycle, when the ALU output for the
  // freshly loaded opcode is sampled into Result/Flags.
  logic              capture_pending;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [OP_W-1:0]   op_code;
  logic [WIDTH-1:0]  result;
  logic [FLAG_W-1:0] flags;

  // Rising-edge detection; prev regs reset high so a held button gives no edge.
  always_comb begin
    enter_edge = Enter & ~enter_prev;
    undo_edge  = Undo & ~undo_prev;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_WAIT_OPA;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; Undo takes priority over Enter, LOAD states ignore buttons.
  always_comb begin
    state_next = state;
    case (state)
      S_WAIT_OPA: begin
        if (enter_edge) state_next = S_LOAD_OPA;
      end
      S_LOAD_OPA: state_next = S_WAIT_OPB;
      S_WAIT_OPB: begin
        if (undo_edge)       state_next = S_WAIT_OPA;
        else if (enter_edge) state_next = S_LOAD_OPB;
      end
      S_LOAD_OPB: state_next = S_WAIT_OP;
      S_WAIT_OP: begin
        if (undo_edge)       state_next = S_WAIT_OPB;
        else if (enter_edge) state_next = S_LOAD_OP;
      end
      S_LOAD_OP: state_next = S_SHOW_RESULT;
      S_SHOW_RESULT: begin
        if (undo_edge)       state_next = S_WAIT_OP;
        else if (enter_edge) state_next = S_WAIT_OPB;
      end
      default: state_next = S_WAIT_OPA;
    endcase
  end

  // Operand, opcode, result and edge-history registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      enter_prev      <= 1'b1;
      undo_prev       <= 1'b1;
      capture_pending <= 1'b0;
      op_a            <= '0;
      op_b            <= '0;
      op_code         <= '0;
      result          <= '0;
      flags           <= '0;
    end else begin
      enter_prev      <= Enter;
      undo_prev       <= Undo;
      capture_pending <= (state == S_LOAD_OP);
      case (state)
        S_LOAD_OPA: op_a    <= DataIn;
        S_LOAD_OPB: op_b    <= DataIn;
        S_LOAD_OP:  op_code <= DataIn[OP_W-1:0];
        S_SHOW_RESULT: begin
          if (undo_edge) begin
            result <= '0;
            flags  <= '0;
          end else begin
            if (capture_pending) begin
              result <= AluResult;
              flags  <= AluFlags;
            end
            // Chaining on the capture cycle must use the value being captured.
            if (enter_edge) begin
              op_a <= capture_pending ? AluResult : result;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Status, valid and display selection derived from the state register.
  always_comb begin
    Status       = state;
    ResultValid  = (state == S_SHOW_RESULT);
    DisplayValue = (state == S_SHOW_RESULT) ? result : DataIn;
  end

  // Register outputs.
  always_comb begin
    OpA    = op_a;
    OpB    = op_b;
    OpCode = op_code;
    Result = result;
    Flags  = flags;
  end

endmodule

// File: tb/tb_rpn_calc_ctrl.sv
// tb_rpn_calc_ctrl: scenario tasks for the RPN entry controller with a small
// ALU stub; expected results are queued when the opcode is entered and
// compared once the controller captures them.

module tb_rpn_calc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        Enter;
  logic        Undo;
  logic [15:0] DataIn;
  logic [15:0] AluResult;
  logic [4:0]  AluFlags;
  logic [15:0] OpA;
  logic [15:0] OpB;
  logic [1:0]  OpCode;
  logic [15:0] Result;
  logic [4:0]  Flags;
  logic [2:0]  Status;
  logic        ResultValid;
  logic [15:0] DisplayValue;

  int vectors = 0;
  int miscompares = 0;
  logic [20:0] sb_q[$];

  rpn_calc_ctrl #(.WIDTH(16), .OP_W(2), .FLAG_W(5)) dut (
    .clk(clk), .reset(reset), .Enter(Enter), .Undo(Undo), .DataIn(DataIn),
    .AluResult(AluResult), .AluFlags(AluFlags), .OpA(OpA), .OpB(OpB),
    .OpCode(OpCode), .Result(Result), .Flags(Flags), .Status(Status),
    .ResultValid(ResultValid), .DisplayValue(DisplayValue)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] flags_of(input logic [16:0] s);
    flags_of = {s[15], (s[15:0] == 16'h0), s[16], 2'b10};
  endfunction

  // ALU stub: add for opcode 0, subtract otherwise.
  logic [16:0] alu_full;
  always_comb begin
    alu_full  = (OpCode == 2'd0) ? ({1'b0, OpA} + {1'b0, OpB}) : ({1'b0, OpA} - {1'b0, OpB});
    AluResult = alu_full[15:0];
    AluFlags  = flags_of(alu_full);
  end

  task automatic press_enter(input logic [15:0] data, output logic [2:0] s1, output logic [2:0] s2);
    @(negedge clk); DataIn = data; Enter = 1'b1;
    @(negedge clk); s1 = Status; Enter = 1'b0;
    @(negedge clk); s2 = Status;
  endtask

  task automatic press_undo(output logic [2:0] s1);
    @(negedge clk); Undo = 1'b1;
    @(negedge clk); s1 = Status; Undo = 1'b0;
    @(negedge clk);
  endtask

  task automatic collect_result(output logic [15:0] r, output logic [4:0] f, output logic [15:0] d,
                                output logic [20:0] exp, output bit timed_out);
    int n = 0;
    while (!ResultValid && n < 10) begin @(negedge clk); n++; end
    timed_out = !ResultValid;
    @(negedge clk);
    r = Result; f = Flags; d = DisplayValue;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 21'hx;
  endtask

  task automatic test_reset();
    reset = 1'b1; Enter = 1'b1; Undo = 1'b0; DataIn = 16'hBEEF;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (Status !== 3'd0) begin miscompares++; $display("FAIL reset_status got=%0d want=0", Status); end
    vectors++; if (OpA !== 16'h0) begin miscompares++; $display("FAIL reset_opa got=%h want=0000", OpA); end
    vectors++; if ({OpB, OpCode, Result, Flags, ResultValid} !== '0) begin miscompares++;
      $display("FAIL reset_regs got=%h/%h/%h/%h/%b want=all zero", OpB, OpCode, Result, Flags, ResultValid); end
    vectors++; if (DisplayValue !== 16'hBEEF) begin miscompares++; $display("FAIL reset_display got=%h want=beef", DisplayValue); end
    Enter = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_compute();
    logic [2:0] s1, s2; logic [15:0] r, d; logic [4:0] f; logic [20:0] exp; bit to;
    press_enter(16'h000A, s1, s2);
    vectors++; if ({s1, s2} !== {3'd1, 3'd2}) begin miscompares++; $display("FAIL opa_states got=%0d,%0d want=1,2", s1, s2); end
    vectors++; if (OpA !== 16'h000A) begin miscompares++; $display("FAIL opa_load got=%h want=000a", OpA); end
    press_enter(16'h0007, s1, s2);
    vectors++; if (OpB !== 16'h0007 || s2 !== 3'd4) begin miscompares++; $display("FAIL opb_load got=%h st=%0d want=0007 st=4", OpB, s2); end
    sb_q.push_back({16'h0011, flags_of(17'h0011)});
    press_enter(16'h0000, s1, s2);
    vectors++; if ({s1, s2} !== {3'd5, 3'd6}) begin miscompares++; $display("FAIL op_states got=%0d,%0d want=5,6", s1, s2); end
    vectors++; if (ResultValid !== 1'b1) begin miscompares++; $display("FAIL result_valid got=%b want=1", ResultValid); end
    collect_result(r, f, d, exp, to);
    vectors++; if (to) begin miscompares++; $display("FAIL add_timeout got=no ResultValid want=ResultValid"); end
    vectors++; if ({r, f} !== exp) begin miscompares++; $display("FAIL add_result got=%h/%h want=%h/%h", r, f, exp[20:5], exp[4:0]); end
    vectors++; if (d !== 16'h0011) begin miscompares++; $display("FAIL add_display got=%h want=0011", d); end
  endtask

  task automatic test_undo();
    logic [2:0] s1, s2; logic [15:0] r, d; logic [4:0] f; logic [20:0] exp; bit to;
    press_undo(s1);
    vectors++; if (s1 !== 3'd4) begin miscompares++; $display("FAIL undo_show got=%0d want=4", s1); end
    press_undo(s1);
    vectors++; if (s1 !== 3'd2) begin miscompares++; $display("FAIL undo_op got=%0d want=2", s1); end
    press_enter(16'h0002, s1, s2);
    vectors++; if (OpB !== 16'h0002 || OpA !== 16'h000A) begin miscompares++; $display("FAIL reload_opb got=%h/%h want=000a/0002", OpA, OpB); end
    sb_q.push_back({16'h000C, flags_of(17'h000C)});
    press_enter(16'h0000, s1, s2);
    collect_result(r, f, d, exp, to);
    vectors++; if (to || {r, f} !== exp) begin miscompares++; $display("FAIL undo_result got=%h/%h to=%b want=%h/%h", r, f, to, exp[20:5], exp[4:0]); end
    DataIn = 16'h1234;
    press_undo(s1);
    vectors++; if (s1 !== 3'd4 || Result !== 16'h0 || Flags !== 5'h0) begin miscompares++;
      $display("FAIL undo_clear got=st%0d %h/%h want=st4 0000/00", s1, Result, Flags); end
    vectors++; if (DisplayValue !== 16'h1234 || ResultValid !== 1'b0) begin miscompares++;
      $display("FAIL undo_display got=%h rv=%b want=1234 rv=0", DisplayValue, ResultValid); end
  endtask

  task automatic test_chain();
    logic [2:0] s1, s2; logic [15:0] r, d; logic [4:0] f; logic [20:0] exp; bit to;
    sb_q.push_back({16'h000C, flags_of(17'h000C)});
    press_enter(16'h0000, s1, s2);
    collect_result(r, f, d, exp, to);
    vectors++; if (to || {r, f} !== exp) begin miscompares++; $display("FAIL rerun_result got=%h/%h want=%h/%h", r, f, exp[20:5], exp[4:0]); end
    press_enter(16'h0003, s1, s2);
    vectors++; if (OpA !== 16'h000C || s1 !== 3'd2 || s2 !== 3'd2) begin miscompares++;
      $display("FAIL chain_opa got=%h st=%0d,%0d want=000c st=2,2", OpA, s1, s2); end
    press_enter(16'h0003, s1, s2);
    vectors++; if (OpB !== 16'h0003 || s2 !== 3'd4) begin miscompares++; $display("FAIL chain_opb got=%h st=%0d want=0003 st=4", OpB, s2); end
    sb_q.push_back({16'h000F, flags_of(17'h000F)});
    press_enter(16'h0000, s1, s2);
    collect_result(r, f, d, exp, to);
    vectors++; if (to || {r, f} !== exp) begin miscompares++; $display("FAIL chain_result got=%h/%h want=%h/%h", r, f, exp[20:5], exp[4:0]); end
  endtask

  task automatic test_simultaneous();
    logic [2:0] s1; int loads = 0;
    press_undo(s1);
    press_undo(s1);
    vectors++; if (s1 !== 3'd2) begin miscompares++; $display("FAIL back_to_opb got=%0d want=2", s1); end
    @(negedge clk); DataIn = 16'h0055; Enter = 1'b1; Undo = 1'b1;
    @(negedge clk);
    vectors++; if (Status !== 3'd0 || OpB !== 16'h0003) begin miscompares++;
      $display("FAIL both_edges got=st%0d opb=%h want=st0 opb=0003", Status, OpB); end
    Enter = 1'b0; Undo = 1'b0;
    @(negedge clk); DataIn = 16'h0077; Enter = 1'b1;
    repeat (10) begin @(negedge clk); if (Status == 3'd1) loads++; end
    Enter = 1'b0;
    @(negedge clk);
    vectors++; if (loads !== 1 || OpA !== 16'h0077 || Status !== 3'd2) begin miscompares++;
      $display("FAIL held_enter got=loads%0d opa=%h st=%0d want=loads1 opa=0077 st=2", loads, OpA, Status); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] s1, s2; logic [15:0] r, d; logic [4:0] f; logic [20:0] exp; bit to;
    press_enter(16'h0001, s1, s2);
    sb_q.push_back({16'h0078, flags_of(17'h0078)});
    press_enter(16'h0000, s1, s2);
    collect_result(r, f, d, exp, to);
    vectors++; if (to || {r, f} !== exp) begin miscompares++; $display("FAIL pre_reset_result got=%h/%h want=%h/%h", r, f, exp[20:5], exp[4:0]); end
    press_enter(16'h0000, s1, s2);
    @(negedge clk); DataIn = 16'h0099; Enter = 1'b1;
    @(negedge clk);
    vectors++; if (Status !== 3'd3 || Result !== 16'h0078) begin miscompares++;
      $display("FAIL pre_reset_state got=st%0d res=%h want=st3 res=0078", Status, Result); end
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    vectors++; if ({Status, OpA, OpB, Result, ResultValid} !== '0) begin miscompares++;
      $display("FAIL mid_reset got=st%0d %h/%h/%h rv=%b want=all zero", Status, OpA, OpB, Result, ResultValid); end
    repeat (3) @(negedge clk);
    vectors++; if (Status !== 3'd0 || OpB !== 16'h0) begin miscompares++;
      $display("FAIL held_through_reset got=st%0d opb=%h want=st0 opb=0000", Status, OpB); end
    Enter = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_compute();
    test_undo();
    test_chain();
    test_simultaneous();
    test_reset_mid();
    vectors++; if (sb_q.size() !== 0) begin miscompares++; $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
